// File: rtl/pe_feeder_if.sv
// pe_feeder_if: host stream, PE controller and result stream signals of pe_feeder.
// slave modport is the feeder's view; master is the host/controller side.
interface pe_feeder_if #(
    parameter int unsigned VECTOR_SIZE = 16,
    parameter int unsigned L_RAM_SIZE  = 4
);
    logic                   s_valid;
    logic                   s_ready;
    logic [VECTOR_SIZE-1:0] s_data;
    logic                   pe_start;
    logic                   pe_done;
    logic [L_RAM_SIZE:0]    pe_rdaddr;
    logic [VECTOR_SIZE-1:0] pe_rddata;
    logic [VECTOR_SIZE-1:0] pe_wrdata;
    logic                   m_valid;
    logic                   m_ready;
    logic [VECTOR_SIZE-1:0] m_data;
    logic                   m_err;

    modport slave (
        input  s_valid, s_data, pe_done, pe_rdaddr, pe_wrdata, m_ready,
        output s_ready, pe_start, pe_rddata, m_valid, m_data, m_err
    );

    modport master (
        output s_valid, s_data, pe_done, pe_rdaddr, pe_wrdata, m_ready,
        input  s_ready, pe_start, pe_rddata, m_valid, m_data, m_err
    );
endinterface

// File: rtl/pe_feeder.sv
// pe_feeder: fills a 2*2^L_RAM_SIZE word operand buffer from a valid/ready stream,
// pulses pe_start, serves the controller's asynchronous read port and returns the
// result on pe_done through an output valid/ready stream.
// Optional WAIT watchdog enabled by defining PE_FEEDER_TIMEOUT_EN.
module pe_feeder #(
    parameter int unsigned VECTOR_SIZE    = 16,
    parameter int unsigned L_RAM_SIZE     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        aclk,
    input  logic        aresetn,
    pe_feeder_if.slave  bus,
    output logic        busy
);

    localparam int unsigned DEPTH = 2 ** (L_RAM_SIZE + 1);

    typedef enum logic [1:0] {
        FILL,
        START,
        WAIT,
        OUT
    } state_t;

    state_t                 state;
    logic [L_RAM_SIZE:0]    wr_cnt;
    logic                   pe_start_q;
    logic                   m_valid_q;
    logic [VECTOR_SIZE-1:0] m_data_q;
    logic [VECTOR_SIZE-1:0] mem [DEPTH];

`ifdef PE_FEEDER_TIMEOUT_EN
    localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] wd_cnt;
    logic        m_err_q;
    assign bus.m_err = m_err_q;
`else
    assign bus.m_err = 1'b0;
`endif

    assign bus.s_ready   = (state == FILL);
    assign busy          = (state != FILL);
    assign bus.pe_start  = pe_start_q;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_data    = m_data_q;
    assign bus.pe_rddata = mem[bus.pe_rdaddr];

    // Operand buffer: written only by accepted FILL transfers, never cleared by reset.
    always_ff @(posedge aclk) begin
        if (aresetn && state == FILL && bus.s_valid) begin
            mem[wr_cnt] <= bus.s_data;
        end
    end

    // Control FSM with registered start pulse and result outputs.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= FILL;
            wr_cnt     <= '0;
            pe_start_q <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
`ifdef PE_FEEDER_TIMEOUT_EN
            wd_cnt     <= '0;
            m_err_q    <= 1'b0;
`endif
        end else begin
            pe_start_q <= 1'b0;
            case (state)
                FILL: begin
                    if (bus.s_valid) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == '1) begin
                            wr_cnt     <= '0;
                            pe_start_q <= 1'b1;
                            state      <= START;
                        end
                    end
                end
                START: begin
`ifdef PE_FEEDER_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.pe_done) begin
                        m_data_q  <= bus.pe_wrdata;
                        m_valid_q <= 1'b1;
`ifdef PE_FEEDER_TIMEOUT_EN
                        m_err_q   <= 1'b0;
`endif
                        state     <= OUT;
                    end
`ifdef PE_FEEDER_TIMEOUT_EN
                    else if (wd_cnt == WD_LIMIT) begin
                        m_data_q  <= '0;
                        m_valid_q <= 1'b1;
                        m_err_q   <= 1'b1;
                        state     <= OUT;
                    end else begin
                        wd_cnt <= wd_cnt + 32'd1;
                    end
`endif
                end
                OUT: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        state     <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_feeder.sv
// tb_pe_feeder: directed self-checking bench for pe_feeder.
// Timeout scenarios run only when PE_FEEDER_TIMEOUT_EN is defined.
module tb_pe_feeder;

    logic aclk;
    logic aresetn;
    logic busy;
    int   n_checks;
    int   n_fail;

    pe_feeder_if #(.VECTOR_SIZE(16), .L_RAM_SIZE(4)) bus_if ();

    pe_feeder #(
        .VECTOR_SIZE   (16),
        .L_RAM_SIZE    (4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .bus    (bus_if),
        .busy   (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Streams 32 words base..base+31; returns one cycle after the last accept (START).
    task automatic fill(input logic [15:0] base);
        bus_if.s_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus_if.s_data = base + 16'(i);
            n_checks++;
            if (bus_if.s_ready !== 1'b1 || bus_if.pe_start !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_accept word %0d: s_ready=%b pe_start=%b, required s_ready=1 pe_start=0",
                         i, bus_if.s_ready, bus_if.pe_start);
            end
            tick();
        end
        bus_if.s_valid = 1'b0;
        n_checks++;
        if (bus_if.pe_start !== 1'b1 || bus_if.s_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_pulse: pe_start=%b s_ready=%b busy=%b, required 1 0 1",
                     bus_if.pe_start, bus_if.s_ready, busy);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus_if.s_ready !== 1'b1 || bus_if.pe_start !== 1'b0 || bus_if.m_valid !== 1'b0 ||
            bus_if.m_data !== 16'h0000 || bus_if.m_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: s_ready=%b pe_start=%b m_valid=%b m_data=%h m_err=%b busy=%b, required 1 0 0 0000 0 0",
                     bus_if.s_ready, bus_if.pe_start, bus_if.m_valid, bus_if.m_data, bus_if.m_err, busy);
        end
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_fill_start();
        fill(16'h0001);
        tick();
        n_checks++;
        if (bus_if.pe_start !== 1'b0 || busy !== 1'b1 || bus_if.s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_entry: pe_start=%b busy=%b s_ready=%b, required 0 1 0",
                     bus_if.pe_start, busy, bus_if.s_ready);
        end
    endtask

    task automatic test_read_port();
        for (int a = 0; a < 32; a++) begin
            bus_if.pe_rdaddr = 5'(a);
            #0.1;
            n_checks++;
            if (bus_if.pe_rddata !== 16'(a + 1)) begin
                n_fail++;
                $display("FAIL read_port addr %0d: pe_rddata=%h, required %h", a, bus_if.pe_rddata, 16'(a + 1));
            end
        end
    endtask

    task automatic test_wait_ignores_input();
        bus_if.s_valid = 1'b1;
        bus_if.s_data  = 16'hDEAD;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (bus_if.s_ready !== 1'b0 || busy !== 1'b1 || bus_if.m_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_hold: s_ready=%b busy=%b m_valid=%b, required 0 1 0",
                         bus_if.s_ready, busy, bus_if.m_valid);
            end
        end
        bus_if.s_valid   = 1'b0;
        bus_if.pe_rdaddr = 5'd0;
        #0.1;
        n_checks++;
        if (bus_if.pe_rddata !== 16'h0001) begin
            n_fail++;
            $display("FAIL wait_no_write: mem[0]=%h, required 0001", bus_if.pe_rddata);
        end
    endtask

    task automatic test_result();
        bus_if.pe_wrdata = 16'h1234;
        bus_if.pe_done   = 1'b1;
        bus_if.m_ready   = 1'b0;
        tick();
        bus_if.pe_done   = 1'b0;
        bus_if.pe_wrdata = 16'h9999;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus_if.m_valid !== 1'b1 || bus_if.m_data !== 16'h1234 || bus_if.m_err !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL result_hold cycle %0d: m_valid=%b m_data=%h m_err=%b busy=%b, required 1 1234 0 1",
                         i, bus_if.m_valid, bus_if.m_data, bus_if.m_err, busy);
            end
            if (i < 4) tick();
        end
        bus_if.m_ready = 1'b1;
        tick();
        bus_if.m_ready = 1'b0;
        n_checks++;
        if (bus_if.m_valid !== 1'b0 || bus_if.s_ready !== 1'b1 || busy !== 1'b0 || bus_if.m_data !== 16'h1234) begin
            n_fail++;
            $display("FAIL result_handshake: m_valid=%b s_ready=%b busy=%b m_data=%h, required 0 1 0 1234",
                     bus_if.m_valid, bus_if.s_ready, busy, bus_if.m_data);
        end
    endtask

    task automatic test_done_in_fill();
        bus_if.pe_done   = 1'b1;
        bus_if.pe_wrdata = 16'hBEEF;
        tick();
        bus_if.pe_done = 1'b0;
        tick();
        n_checks++;
        if (bus_if.s_ready !== 1'b1 || bus_if.m_valid !== 1'b0 || bus_if.pe_start !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_in_fill: s_ready=%b m_valid=%b pe_start=%b busy=%b, required 1 0 0 0",
                     bus_if.s_ready, bus_if.m_valid, bus_if.pe_start, busy);
        end
    endtask

    task automatic test_reset_midfill();
        bus_if.s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus_if.s_data = 16'h0100 + 16'(i);
            tick();
        end
        bus_if.s_valid = 1'b0;
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        n_checks++;
        if (bus_if.s_ready !== 1'b1 || busy !== 1'b0 || bus_if.pe_start !== 1'b0) begin
            n_fail++;
            $display("FAIL midfill_reset: s_ready=%b busy=%b pe_start=%b, required 1 0 0",
                     bus_if.s_ready, busy, bus_if.pe_start);
        end
        fill(16'h0A01);
        bus_if.pe_rdaddr = 5'd0;
        #0.1;
        n_checks++;
        if (bus_if.pe_rddata !== 16'h0A01) begin
            n_fail++;
            $display("FAIL midfill_first_word: mem[0]=%h, required 0a01", bus_if.pe_rddata);
        end
        bus_if.pe_rdaddr = 5'd31;
        #0.1;
        n_checks++;
        if (bus_if.pe_rddata !== 16'h0A20) begin
            n_fail++;
            $display("FAIL midfill_last_word: mem[31]=%h, required 0a20", bus_if.pe_rddata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bus_if.pe_done   = 1'b1;
        bus_if.pe_wrdata = 16'h5555;
        bus_if.m_ready   = 1'b1;
        tick();
        bus_if.pe_done = 1'b0;
        n_checks++;
        if (bus_if.m_valid !== 1'b1 || bus_if.m_data !== 16'h5555 || bus_if.m_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_result: m_valid=%b m_data=%h m_err=%b, required 1 5555 0",
                     bus_if.m_valid, bus_if.m_data, bus_if.m_err);
        end
        tick();
        bus_if.m_ready = 1'b0;
        n_checks++;
        if (bus_if.m_valid !== 1'b0 || bus_if.s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_refill: m_valid=%b s_ready=%b, required 0 1", bus_if.m_valid, bus_if.s_ready);
        end
    endtask

`ifdef PE_FEEDER_TIMEOUT_EN
    task automatic test_timeout();
        fill(16'h0300);
        tick();
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (bus_if.m_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_early wait cycle %0d: m_valid=%b, required 0", i, bus_if.m_valid);
            end
            tick();
        end
        n_checks++;
        if (bus_if.m_valid !== 1'b1 || bus_if.m_data !== 16'h0000 || bus_if.m_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_abort: m_valid=%b m_data=%h m_err=%b, required 1 0000 1",
                     bus_if.m_valid, bus_if.m_data, bus_if.m_err);
        end
        bus_if.m_ready = 1'b1;
        tick();
        bus_if.m_ready = 1'b0;

        fill(16'h0400);
        tick();
        for (int i = 0; i < 7; i++) tick();
        bus_if.pe_done   = 1'b1;
        bus_if.pe_wrdata = 16'h4321;
        tick();
        bus_if.pe_done = 1'b0;
        n_checks++;
        if (bus_if.m_valid !== 1'b1 || bus_if.m_data !== 16'h4321 || bus_if.m_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_done_wins: m_valid=%b m_data=%h m_err=%b, required 1 4321 0",
                     bus_if.m_valid, bus_if.m_data, bus_if.m_err);
        end
        bus_if.m_ready = 1'b1;
        tick();
        bus_if.m_ready = 1'b0;
    endtask
`endif

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        aresetn          = 1'b0;
        bus_if.s_valid   = 1'b0;
        bus_if.s_data    = '0;
        bus_if.pe_done   = 1'b0;
        bus_if.pe_rdaddr = '0;
        bus_if.pe_wrdata = '0;
        bus_if.m_ready   = 1'b0;

        test_reset();
        test_fill_start();
        test_read_port();
        test_wait_ignores_input();
        test_result();
        test_done_in_fill();
        test_reset_midfill();
        test_back_to_back();
`ifdef PE_FEEDER_TIMEOUT_EN
        test_timeout();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
